// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared CPU constants: bubble word, opcodes, fetch FSM encoding
package if_stage_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BZ  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Branch offsets are relative to the word after the branch.
  function automatic logic [15:0] branch_target(input logic [15:0] pc, input logic [5:0] off);
    return pc + 16'd1 + {{10{off[5]}}, off};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/response bus
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/if_stage_fetch_fifo.sv
// rtl/if_stage_fetch_fifo.sv - small circular fetch queue with flush
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: single-outstanding imem requests, fetch queue, IF/ID register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_WORD,
  parameter int          QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              stall_mem_ready,
  input  logic              branch_taken,
  input  logic [5:0]        branch_offset_imm,
  if_stage_if.master        imem,
  output logic [15:0]       if_id_instr,
  output logic [15:0]       if_id_pc,
  output logic [15:0]       pc_out
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  if_id_instr_q, if_id_instr_d;
  logic [15:0]  if_id_pc_q, if_id_pc_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;

  logic          redirect, advance, rsp_live, bypass, push, pop;
  logic [CW:0]   occ_next;
  logic          issue_ok, issue, req;
  logic [15:0]   req_addr;

  assign redirect = branch_taken && !stall_mem_ready;
  assign advance  = !stall && !stall_mem_ready && !branch_taken;
  assign rsp_live = imem.imem_valid && (state_q == ST_REQ);
  // An empty queue lets the arriving word flow straight into IF/ID.
  assign bypass   = advance && fifo_empty && rsp_live;
  assign push     = rsp_live && !redirect && !bypass && (!fifo_full || pop);
  assign pop      = advance && !fifo_empty;
  assign occ_next = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign issue_ok = rst && !redirect && (occ_next < (CW+1)'(QDEPTH));

  fetch_fifo #(.WIDTH(32), .DEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i ({addr_q, imem.imem_rdata}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // A completing response frees the bus in the same cycle, so REQ can chain requests back to back.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req      = 1'b0;
    req_addr = addr_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: issue = issue_ok;
      ST_REQ: begin
        if (!imem.imem_valid) begin
          req = 1'b1;
          if (redirect) state_d = ST_DRAIN;
        end else if (issue_ok) begin
          issue = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!imem.imem_valid) req = 1'b1;
        else                  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      req      = 1'b1;
      req_addr = pc_q;
      addr_d   = pc_q;
      pc_d     = pc_q + 16'd1;
      state_d  = ST_REQ;
    end
    if (redirect) pc_d = branch_target(if_id_pc_q, branch_offset_imm);
  end

  always_comb begin
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if (redirect) begin
      if_id_instr_d = NOP_INSTR;
    end else if (advance) begin
      if (!fifo_empty) begin
        if_id_pc_d    = fifo_head[31:16];
        if_id_instr_d = fifo_head[15:0];
      end else if (bypass) begin
        if_id_pc_d    = addr_q;
        if_id_instr_d = imem.imem_rdata;
      end else begin
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = req_addr;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign pc_out         = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage with a variable-latency memory model
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall, smr, br;
  logic [5:0]  off;
  logic [15:0] if_id_instr, if_id_pc, pc_out;

  int n_vec = 0;
  int n_bad = 0;

  if_stage_if imem();

  if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000), .QDEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .stall_mem_ready   (smr),
    .branch_taken      (br),
    .branch_offset_imm (off),
    .imem              (imem),
    .if_id_instr       (if_id_instr),
    .if_id_pc          (if_id_pc),
    .pc_out            (pc_out)
  );

  always #5 clk = ~clk;

  // Memory: accepts a request when idle, answers addr+16'h1000 after lat cycles.
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [15:0] paddr = '0;
  logic        nv;
  logic [15:0] nd;

  always begin
    @(negedge clk);
    nv = 1'b0;
    nd = 16'h0000;
    if (!rst) begin
      pend = 0;
    end else begin
      if (imem.imem_valid) pend = 0;
      if (!pend && imem.imem_req) begin
        pend  = 1;
        cnt   = lat;
        paddr = imem.imem_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          nv = 1'b1;
          nd = paddr + 16'h1000;
        end
      end
    end
    @(posedge clk);
    #1;
    imem.imem_valid = nv;
    imem.imem_rdata = nd;
  end

  typedef struct {
    logic        stall, smr, br;
    logic [5:0]  off;
    logic        req;
    logic [15:0] addr, instr, pc, pcout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic m, input logic b, input logic [5:0] o);
    stall = s; smr = m; br = b; off = o;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 6'h00);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    set_in(0, 0, 0, 6'h00);
    imem.imem_valid = 1'b0;
    imem.imem_rdata = 16'h0000;

    // stall, smr, br, off, req, addr, instr, pc, pc_out
    vecs.push_back('{0,0,0,6'h00, 1,16'h0000, 16'h0000,16'h0000, 16'h0000});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0001, 16'h0000,16'h0000, 16'h0001});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0002, 16'h1000,16'h0000, 16'h0002});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0003, 16'h1001,16'h0001, 16'h0003});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0004, 16'h1002,16'h0002, 16'h0004});
    vecs.push_back('{1,0,0,6'h00, 1,16'h0005, 16'h1003,16'h0003, 16'h0005});
    vecs.push_back('{1,0,0,6'h00, 0,16'h0000, 16'h1003,16'h0003, 16'h0006});
    vecs.push_back('{1,0,0,6'h00, 0,16'h0000, 16'h1003,16'h0003, 16'h0006});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0006, 16'h1003,16'h0003, 16'h0006});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0007, 16'h1004,16'h0004, 16'h0007});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0008, 16'h1005,16'h0005, 16'h0008});
    vecs.push_back('{0,0,1,6'h05, 0,16'h0000, 16'h1006,16'h0006, 16'h0009});
    vecs.push_back('{0,0,0,6'h00, 1,16'h000C, 16'h0000,16'h0006, 16'h000C});
    vecs.push_back('{0,0,0,6'h00, 1,16'h000D, 16'h0000,16'h0006, 16'h000D});
    vecs.push_back('{0,0,0,6'h00, 1,16'h000E, 16'h100C,16'h000C, 16'h000E});
    vecs.push_back('{0,0,0,6'h00, 1,16'h000F, 16'h100D,16'h000D, 16'h000F});
    vecs.push_back('{0,1,1,6'h3E, 1,16'h0010, 16'h100E,16'h000E, 16'h0010});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0011, 16'h100E,16'h000E, 16'h0011});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0012, 16'h100F,16'h000F, 16'h0012});
    vecs.push_back('{0,0,1,6'h3E, 0,16'h0000, 16'h1010,16'h0010, 16'h0013});
    vecs.push_back('{0,0,0,6'h00, 1,16'h000F, 16'h0000,16'h0010, 16'h000F});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0010, 16'h0000,16'h0010, 16'h0010});
    vecs.push_back('{0,0,0,6'h00, 1,16'h0011, 16'h100F,16'h000F, 16'h0011});

    #2;
    chk("reset req",   {15'd0, imem.imem_req}, 16'h0000);
    chk("reset instr", if_id_instr, 16'h0000);
    chk("reset pc",    if_id_pc,    16'h0000);
    chk("reset pcout", pc_out,      16'h0000);

    // Streaming, stall, redirect and ignored-redirect table, 1-cycle memory.
    do_reset();
    lat = 1;
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].stall, vecs[i].smr, vecs[i].br, vecs[i].off);
      @(negedge clk);
      chk($sformatf("row%0d req", i), {15'd0, imem.imem_req}, {15'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("row%0d addr", i), imem.imem_addr, vecs[i].addr);
      chk($sformatf("row%0d instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("row%0d pc", i),    if_id_pc,    vecs[i].pc);
      chk($sformatf("row%0d pcout", i), pc_out,      vecs[i].pcout);
      step();
    end

    // Fetch PC wrap: redirect from pc 0 with offset -2 targets 16'hFFFF.
    do_reset();
    lat = 1;
    set_in(0, 0, 1, 6'h3E);
    rst = 1'b1;
    @(negedge clk);
    chk("wrap c0 req", {15'd0, imem.imem_req}, 16'h0000);
    step();
    set_in(0, 0, 0, 6'h00);
    @(negedge clk);
    chk("wrap c1 addr", imem.imem_addr, 16'hFFFF);
    step();
    @(negedge clk);
    chk("wrap c2 addr", imem.imem_addr, 16'h0000);
    step();
    @(negedge clk);
    chk("wrap c3 instr", if_id_instr, 16'h0FFF);
    chk("wrap c3 pc",    if_id_pc,    16'hFFFF);
    step();
    @(negedge clk);
    chk("wrap c4 instr", if_id_instr, 16'h1000);
    chk("wrap c4 pc",    if_id_pc,    16'h0000);

    // Redirect while a 3-cycle response is outstanding.
    do_reset();
    lat = 3;
    rst = 1'b1;
    @(negedge clk);
    chk("stale c0 addr", imem.imem_addr, 16'h0000);
    step();
    set_in(0, 0, 1, 6'h05);
    @(negedge clk);
    chk("stale c1 req", {15'd0, imem.imem_req}, 16'h0001);
    step();
    set_in(0, 0, 0, 6'h00);
    @(negedge clk);
    chk("stale c2 req",  {15'd0, imem.imem_req}, 16'h0001);
    chk("stale c2 addr", imem.imem_addr, 16'h0000);
    step();
    @(negedge clk);
    chk("stale c3 req", {15'd0, imem.imem_req}, 16'h0000);
    step();
    @(negedge clk);
    chk("stale c4 req",  {15'd0, imem.imem_req}, 16'h0001);
    chk("stale c4 addr", imem.imem_addr, 16'h0006);
    for (int c = 4; c < 8; c++) begin
      chk($sformatf("stale c%0d instr", c), if_id_instr, 16'h0000);
      step();
      @(negedge clk);
    end
    chk("stale c8 instr", if_id_instr, 16'h1006);
    chk("stale c8 pc",    if_id_pc,    16'h0006);

    // Asynchronous reset while fetching 16'h0042.
    do_reset();
    lat = 1;
    rst = 1'b1;
    begin
      bit found = 0;
      for (int c = 0; c < 300 && !found; c++) begin
        @(negedge clk);
        if (imem.imem_req && imem.imem_addr == 16'h0042) found = 1;
      end
      n_vec++;
      if (!found) begin
        n_bad++;
        $display("FAIL arst reach: got no request at 0042 expected one within 300 cycles");
      end
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst req",   {15'd0, imem.imem_req}, 16'h0000);
    chk("arst instr", if_id_instr, 16'h0000);
    chk("arst pc",    if_id_pc,    16'h0000);
    chk("arst pcout", pc_out,      16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("arst rel req",  {15'd0, imem.imem_req}, 16'h0001);
    chk("arst rel addr", imem.imem_addr, 16'h0000);
    for (int c = 0; c < 10 && if_id_instr == 16'h0000; c++) begin
      step();
      @(negedge clk);
    end
    chk("arst first instr", if_id_instr, 16'h1000);
    chk("arst first pc",    if_id_pc,    16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 16'h0000, bubble word (opcode 0) driven into IF/ID.
REQ-003 Parameter QDEPTH, 2, fetch-queue entries (power of two, >=2).
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  load-use hazard; hold IF/ID contents.
REQ-007 stall_mem_ready  in  1  global freeze while data memory busy.
REQ-008 branch_taken  in  1  BZ resolved taken in decode this cycle.
REQ-009 branch_offset_imm  in  6  signed word offset of the taken BZ.
REQ-010 imem_req  out  1  instruction-memory request valid.
REQ-011 imem_addr  out  16  word address of request.
REQ-012 imem_valid  in  1  response strobe, one per accepted request, latency >=1 cycle.
REQ-013 imem_rdata  in  16  instruction word, qualified by imem_valid.
REQ-014 if_id_instr  out  16  registered instruction to decode.
REQ-015 if_id_pc  out  16  registered PC of if_id_instr.
REQ-016 pc_out  out  16  next fetch PC (debug).

Function
REQ-017 SHALL keep at most one request outstanding; imem_req and imem_addr held stable from assertion until the cycle imem_valid is seen.
REQ-018 SHALL assert a new request only when (queue occupancy + outstanding) < QDEPTH and no redirect is in progress; fetch PC increments by 1 (mod 2^16) per issued request.
REQ-019 SHALL push {fetch address, imem_rdata} into the queue on imem_valid unless the response is marked stale.
REQ-020 IF/ID advance: when stall=0 and stall_mem_ready=0 and branch_taken=0, load queue head (pop) if non-empty, else load NOP_INSTR with if_id_pc unchanged.
REQ-021 When stall=1 or stall_mem_ready=1, IF/ID SHALL hold; queue may still fill and requests may still issue.
REQ-022 branch_taken=1 (with stall_mem_ready=0) SHALL: set fetch PC = if_id_pc + 1 + sext(branch_offset_imm) mod 2^16; flush queue; load NOP_INSTR into IF/ID; mark any outstanding request stale.
REQ-023 branch_taken with stall_mem_ready=1 SHALL be ignored that cycle.
REQ-024 FSM states: IDLE (no request), REQ (request outstanding), DRAIN (stale response pending, imem_req low after current one completes); REQ->DRAIN on redirect, DRAIN->IDLE on imem_valid (response dropped), IDLE->REQ when REQ-018 permits.
REQ-025 imem_valid and redirect in the same cycle: response SHALL be dropped, FSM to IDLE, new fetch at target next cycle.
REQ-026 Push and pop in the same cycle at full queue SHALL both succeed; push never occurs when full (guaranteed by REQ-018).
REQ-027 Minimum taken-branch penalty: target instruction in IF/ID 2 cycles after redirect with 1-cycle memory.

Reset
REQ-028 Asserting rst SHALL immediately clear: fetch PC=RESET_PC, queue empty, FSM=IDLE, imem_req=0, if_id_instr=NOP_INSTR, if_id_pc=0.
REQ-029 Reset mid-request SHALL discard the transaction; the first request after release issues at RESET_PC on the first clock edge with rst high.

Structure
REQ-030 NOP_INSTR, opcode constants and FSM state encoding SHALL live in the shared CPU package used by decode.
REQ-031 Queue SHALL be a sub-module fetch_fifo (parameterised width 32, depth QDEPTH, full/empty/count).

Verification
REQ-032 Reset release, 1-cycle memory returning addr+16'h1000 -> IF/ID shows 16'h1000,16'h1001,16'h1002 on consecutive cycles, pc 0,1,2.
REQ-033 stall=1 for 3 cycles -> IF/ID holds value, imem_req drops after queue holds 2 entries, stream resumes without loss or duplication.
REQ-034 branch_taken with if_id_pc=16'h0010, offset 6'h3E -> next fetch address 16'h000F, queued words flushed, IF/ID=NOP_INSTR.
REQ-035 Redirect while 3-cycle-latency response outstanding -> stale word never reaches IF/ID; first post-branch request issued after its imem_valid.
REQ-036 rst low mid-request, PC=16'h0042 -> outputs at reset values asynchronously; first request after release at RESET_PC.
REQ-037 Fetch PC 16'hFFFF -> next request 16'h0000.
